ped_request_unit: RTL and testbench

Pedestrian-side front end for `traffic_controller`. It debounces the raw NS and EW crossing buttons and latches each press as a request. It drives the controller's `in_ped_ns` and `in_ped_ew` request inputs and consumes its `out_ped_*` grants and `signal_*` lamp states. It generates timed walk indications with a safety interlock against the vehicle signals.

---
 rtl/ped_request_unit_if.sv | 29 ++
 rtl/ped_request_unit.sv | 189 ++++++++++++++++++
 tb/tb_ped_request_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ped_request_unit_if.sv
// Pedestrian front-end signal bundle: buttons, controller handshake, lamps and status.
interface ped_request_unit_if #(
  parameter int WALK_CYCLES = 8
);
  localparam int WCW = $clog2(WALK_CYCLES + 1);

  logic           btn_ns, btn_ew;
  logic           out_ped_ns, out_ped_ew;
  logic [2:0]     signal_ns, signal_ew;
  logic           in_ped_ns, in_ped_ew;
  logic           walk_ns, walk_ew;
  logic [WCW-1:0] walk_cnt_ns, walk_cnt_ew;
  logic           overdue_ns, overdue_ew;
  logic           fault;

  // Pedestrian unit side
  modport master (
    input  btn_ns, btn_ew, out_ped_ns, out_ped_ew, signal_ns, signal_ew,
    output in_ped_ns, in_ped_ew, walk_ns, walk_ew, walk_cnt_ns, walk_cnt_ew,
           overdue_ns, overdue_ew, fault
  );

  // Controller / environment side
  modport slave (
    output btn_ns, btn_ew, out_ped_ns, out_ped_ew, signal_ns, signal_ew,
    input  in_ped_ns, in_ped_ew, walk_ns, walk_ew, walk_cnt_ns, walk_cnt_ew,
           overdue_ns, overdue_ew, fault
  );
endinterface

// File: rtl/ped_request_unit.sv
// Pedestrian request unit: per-direction button debounce, request latch,
// timed walk with vehicle-signal interlock. Two identical channels.

// One crossing direction.
module ped_chan #(
  parameter int DEB_CYCLES  = 4,
  parameter int WALK_CYCLES = 8,
  parameter int MAX_WAIT    = 32,
  localparam int WCW        = $clog2(WALK_CYCLES + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btn_i,
  input  logic           grant_i,
  input  logic [2:0]     sig_i,
  output logic           req_o,
  output logic           walk_o,
  output logic [WCW-1:0] walk_cnt_o,
  output logic           overdue_o,
  output logic           fault_o
);
  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int WTW = $clog2(MAX_WAIT + 1);
  localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_CYCLES - 1);
  localparam logic [WCW-1:0] WALK_LOAD = WCW'(WALK_CYCLES);
  localparam logic [WCW-1:0] WALK_ONE  = WCW'(1);
  localparam logic [WTW-1:0] WAIT_MAX  = WTW'(MAX_WAIT);
  localparam logic [WTW-1:0] WAIT_PRE  = WTW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WALK, HOLD} state_e;

  logic           sync1_q, sync2_q;
  logic           deb_q, deb_prev_q;
  logic [DCW-1:0] deb_cnt_q;
  logic           press;
  logic           red;
  state_e         state_q;
  logic [WTW-1:0] wait_q;
  logic [WCW-1:0] walk_cnt_q;
  logic           req_q, walk_q, overdue_q, fault_q;

  // Exact one-hot RED only; any malformed lamp code counts as not-red.
  assign red   = (sig_i == 3'b100);
  assign press = deb_q & ~deb_prev_q;

  // Two-flop synchronizer for the raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: toggle the level after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      deb_prev_q <= deb_q;
      if (sync2_q == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        deb_q     <= ~deb_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  // Request/walk FSM; all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      walk_cnt_q <= '0;
      req_q      <= 1'b0;
      walk_q     <= 1'b0;
      overdue_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            state_q   <= REQ;
            req_q     <= 1'b1;
            wait_q    <= '0;
            overdue_q <= 1'b0;
          end
        end
        REQ: begin
          if (grant_i && red) begin
            state_q    <= WALK;
            req_q      <= 1'b0;
            walk_q     <= 1'b1;
            walk_cnt_q <= WALK_LOAD;
            overdue_q  <= 1'b0;
          end else begin
            if (wait_q != WAIT_MAX) wait_q <= wait_q + 1'b1;
            // Look one ahead so overdue lines up with wait reaching MAX_WAIT.
            overdue_q <= (wait_q >= WAIT_PRE);
          end
        end
        WALK: begin
          // Interlock beats every other exit.
          if (!red) begin
            state_q    <= HOLD;
            walk_q     <= 1'b0;
            walk_cnt_q <= '0;
            fault_q    <= 1'b1;
          end else if (!grant_i || walk_cnt_q == WALK_ONE) begin
            state_q    <= HOLD;
            walk_q     <= 1'b0;
            walk_cnt_q <= '0;
          end else begin
            walk_cnt_q <= walk_cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (!grant_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_o      = req_q;
  assign walk_o     = walk_q;
  assign walk_cnt_o = walk_cnt_q;
  assign overdue_o  = overdue_q;
  assign fault_o    = fault_q;
endmodule

// Top: channel 0 = NS, channel 1 = EW.
module ped_request_unit #(
  parameter int DEB_CYCLES  = 4,
  parameter int WALK_CYCLES = 8,
  parameter int MAX_WAIT    = 32
) (
  input  logic               clk,
  input  logic               rst,
  ped_request_unit_if.master bus
);
  localparam int NUM_CH = 2;
  localparam int WCW    = $clog2(WALK_CYCLES + 1);

  logic [NUM_CH-1:0]          btn, grant, req, walk, overdue, flt;
  logic [NUM_CH-1:0][2:0]     sig;
  logic [NUM_CH-1:0][WCW-1:0] wcnt;

  assign btn   = {bus.btn_ew, bus.btn_ns};
  assign grant = {bus.out_ped_ew, bus.out_ped_ns};
  assign sig   = {bus.signal_ew, bus.signal_ns};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ped_chan #(
      .DEB_CYCLES (DEB_CYCLES),
      .WALK_CYCLES(WALK_CYCLES),
      .MAX_WAIT   (MAX_WAIT)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_i     (btn[i]),
      .grant_i   (grant[i]),
      .sig_i     (sig[i]),
      .req_o     (req[i]),
      .walk_o    (walk[i]),
      .walk_cnt_o(wcnt[i]),
      .overdue_o (overdue[i]),
      .fault_o   (flt[i])
    );
  end

  assign bus.in_ped_ns   = req[0];
  assign bus.in_ped_ew   = req[1];
  assign bus.walk_ns     = walk[0];
  assign bus.walk_ew     = walk[1];
  assign bus.walk_cnt_ns = wcnt[0];
  assign bus.walk_cnt_ew = wcnt[1];
  assign bus.overdue_ns  = overdue[0];
  assign bus.overdue_ew  = overdue[1];
  // Each channel flag is sticky, so the OR is sticky too.
  assign bus.fault       = |flt;
endmodule

// File: tb/tb_ped_request_unit.sv
// Directed bench for ped_request_unit (DEB=4, WALK=8, MAX_WAIT=32).
module tb_ped_request_unit;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  ped_request_unit_if #(.WALK_CYCLES(8)) bus ();

  ped_request_unit #(
    .DEB_CYCLES (4),
    .WALK_CYCLES(8),
    .MAX_WAIT   (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance n rising edges, then settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.btn_ns = 0; bus.btn_ew = 0;
    bus.out_ped_ns = 0; bus.out_ped_ew = 0;
    bus.signal_ns = 3'b100; bus.signal_ew = 3'b100;
    step(3);
    chk("rst_in_ped_ns", bus.in_ped_ns, 0);
    chk("rst_walk_ns", bus.walk_ns, 0);
    chk("rst_walk_cnt_ns", bus.walk_cnt_ns, 0);
    chk("rst_overdue_ew", bus.overdue_ew, 0);
    chk("rst_fault", bus.fault, 0);
    rst = 1'b0;

    // NS press held: request appears after edge 7.
    bus.btn_ns = 1;
    step(6);
    chk("ns_press_e6", bus.in_ped_ns, 0);
    step(1);
    chk("ns_press_e7", bus.in_ped_ns, 1);
    chk("ns_press_ew", bus.in_ped_ew, 0);
    chk("ns_press_fault", bus.fault, 0);
    bus.btn_ns = 0;

    // EW 2-clock glitch rejected, then a 10-clock press accepted.
    bus.btn_ew = 1;
    step(2);
    bus.btn_ew = 0;
    step(10);
    chk("ew_glitch", bus.in_ped_ew, 0);
    bus.btn_ew = 1;
    step(6);
    chk("ew_press_e6", bus.in_ped_ew, 0);
    step(1);
    chk("ew_press_e7", bus.in_ped_ew, 1);
    step(3);
    bus.btn_ew = 0;

    // EW grant drops after one walk clock: HOLD then IDLE.
    bus.out_ped_ew = 1;
    step(1);
    chk("ew_walk_start", bus.walk_ew, 1);
    chk("ew_cnt_load", bus.walk_cnt_ew, 8);
    chk("ew_req_drop", bus.in_ped_ew, 0);
    bus.out_ped_ew = 0;
    step(1);
    chk("ew_early_drop", bus.walk_ew, 0);
    chk("ew_early_cnt", bus.walk_cnt_ew, 0);
    step(1);
    chk("ew_idle_req", bus.in_ped_ew, 0);

    // NS full walk: 8 clocks, count 8..1 then 0.
    bus.out_ped_ns = 1;
    step(1);
    chk("ns_walk_start", bus.walk_ns, 1);
    chk("ns_cnt_load", bus.walk_cnt_ns, 8);
    chk("ns_req_drop", bus.in_ped_ns, 0);
    for (int i = 7; i >= 1; i--) begin
      step(1);
      chk("ns_walk_cnt", bus.walk_cnt_ns, i);
      chk("ns_walk_on", bus.walk_ns, 1);
    end
    step(1);
    chk("ns_walk_end", bus.walk_ns, 0);
    chk("ns_hold_cnt", bus.walk_cnt_ns, 0);
    bus.out_ped_ns = 0;
    step(1);
    chk("ns_back_idle", bus.in_ped_ns, 0);
    bus.btn_ns = 1;
    step(7);
    chk("ns_repress", bus.in_ped_ns, 1);
    bus.btn_ns = 0;

    // NS interlock at count 5.
    bus.out_ped_ns = 1;
    step(4);
    chk("ns_cnt5", bus.walk_cnt_ns, 5);
    bus.signal_ns = 3'b001;
    step(1);
    chk("ilk_walk", bus.walk_ns, 0);
    chk("ilk_cnt", bus.walk_cnt_ns, 0);
    chk("ilk_fault", bus.fault, 1);
    bus.signal_ns = 3'b100;
    bus.out_ped_ns = 0;
    step(5);
    chk("fault_sticky", bus.fault, 1);

    // Simultaneous presses, then overdue on both.
    bus.btn_ns = 1;
    bus.btn_ew = 1;
    step(7);
    chk("sim_ns", bus.in_ped_ns, 1);
    chk("sim_ew", bus.in_ped_ew, 1);
    bus.btn_ns = 0;
    bus.btn_ew = 0;
    step(31);
    chk("ovd_ew_e31", bus.overdue_ew, 0);
    step(1);
    chk("ovd_ew_e32", bus.overdue_ew, 1);
    chk("ovd_ns_e32", bus.overdue_ns, 1);
    chk("ovd_req_held", bus.in_ped_ew, 1);
    bus.out_ped_ew = 1;
    step(1);
    chk("ovd_ew_clear", bus.overdue_ew, 0);
    chk("ovd_ew_walk", bus.walk_ew, 1);
    chk("ovd_ns_still", bus.overdue_ns, 1);

    // NS walk, asynchronous reset at count 3.
    bus.out_ped_ns = 1;
    step(1);
    chk("ns2_walk", bus.walk_ns, 1);
    step(5);
    chk("ns2_cnt3", bus.walk_cnt_ns, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_walk_ns", bus.walk_ns, 0);
    chk("arst_cnt_ns", bus.walk_cnt_ns, 0);
    chk("arst_walk_ew", bus.walk_ew, 0);
    chk("arst_in_ped", {30'd0, bus.in_ped_ew, bus.in_ped_ns}, 0);
    chk("arst_overdue", {30'd0, bus.overdue_ew, bus.overdue_ns}, 0);
    chk("arst_fault", bus.fault, 0);
    step(1);
    rst = 1'b0;

    // Grant held in IDLE is ignored.
    step(4);
    chk("idle_grant_walk", bus.walk_ns, 0);
    chk("idle_grant_req", bus.in_ped_ns, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
